// File: rtl/galvo_pkg.sv
// Shared types and constants for the galvo DAC sequencer: FSM states, DAC word config bits, channel ids.
package galvo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_A,
    GAP_A,
    SHIFT_B,
    GAP_B,
    LATCH,
    DWELL
  } state_t;

  localparam logic BUF  = 1'b0;  // unbuffered reference
  localparam logic GA   = 1'b1;  // 1x gain
  localparam logic SHDN = 1'b1;  // output active

  localparam logic CH_X = 1'b0;
  localparam logic CH_Y = 1'b1;

  localparam int CLK_DIV_DEF   = 4;
  localparam int CS_GAP_DEF    = 4;
  localparam int LATCH_CYC_DEF = 4;

  function automatic logic [15:0] dac_word(input logic ch, input logic [11:0] data);
    return {ch, BUF, GA, SHDN, data};
  endfunction

endpackage

// File: rtl/galvo_dac_sequencer_if.sv
// Point stream into the sequencer: valid/ready handshake plus X/Y codes, laser colour and dwell.
interface galvo_dac_sequencer_if;
  logic        pt_valid;
  logic        pt_ready;
  logic [11:0] pt_x;
  logic [11:0] pt_y;
  logic [2:0]  pt_rgb;
  logic [15:0] pt_dwell;

  modport master (output pt_valid, pt_x, pt_y, pt_rgb, pt_dwell, input pt_ready);
  modport slave  (input pt_valid, pt_x, pt_y, pt_rgb, pt_dwell, output pt_ready);
endinterface

// File: rtl/dac_word_shifter.sv
// Serialises one 16-bit DAC word MSB first; csn low for exactly 32*CLK_DIV cycles after load_i.
// done_o pulses on the final cycle of the word; load_i must only be given while idle.
module dac_word_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] word_i,
  output logic        done_o,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        csn_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [15:0]   shreg_q, shreg_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          csn_q, csn_d;
  logic          tick;

  assign tick   = !csn_q && (div_q == DW'(CLK_DIV - 1));
  assign done_o = tick && sclk_q && (bit_q == 4'd15);

  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    if (load_i) begin
      shreg_d = word_i;
      bit_d   = 4'd0;
      div_d   = '0;
      sclk_d  = 1'b0;
      mosi_d  = word_i[15];
      csn_d   = 1'b0;
    end else if (!csn_q) begin
      if (tick) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_q == 4'd15) begin
          sclk_d = 1'b0;
          mosi_d = 1'b0;
          csn_d  = 1'b1;
        end else begin
          // mosi moves together with the falling sclk edge, so it is stable for the whole high phase
          sclk_d  = 1'b0;
          bit_d   = bit_q + 4'd1;
          shreg_d = {shreg_q[14:0], 1'b0};
          mosi_d  = shreg_q[14];
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign csn_o  = csn_q;

endmodule

// File: rtl/galvo_dac_sequencer.sv
// Point sequencer: sends X then Y to a dual DAC, pulses latchn, updates laser, dwells; 268+dwell busy cycles per point.
// Backpressure: pt_ready is high only in IDLE, so a held pt_valid is taken on the first IDLE cycle.
module galvo_dac_sequencer
  import galvo_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int CS_GAP    = CS_GAP_DEF,
  parameter int LATCH_CYC = LATCH_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  galvo_dac_sequencer_if.slave  pt,
  output logic                  dac_csn,
  output logic                  dac_sclk,
  output logic                  dac_mosi,
  output logic                  dac_latchn,
  output logic [2:0]            laser_rgb,
  output logic                  busy
);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] y_q;
  logic [2:0]  rgb_q;
  logic [15:0] dwell_q;
  logic [2:0]  laser_q, laser_d;
  logic        latchn_q, latchn_d;
  logic        ready_q;
  logic        accept;
  logic        load;
  logic        done;
  logic [15:0] word;

  assign accept = pt.pt_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    load     = 1'b0;
    word     = dac_word(CH_X, pt.pt_x);
    latchn_d = latchn_q;
    laser_d  = laser_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT_A;
          load    = 1'b1;
        end
      end
      SHIFT_A: begin
        if (done) begin
          state_d = GAP_A;
          cnt_d   = 16'd0;
        end
      end
      GAP_A: begin
        word = dac_word(CH_Y, y_q);
        if (cnt_q == 16'(CS_GAP - 1)) begin
          state_d = SHIFT_B;
          load    = 1'b1;
        end
      end
      SHIFT_B: begin
        if (done) begin
          state_d = GAP_B;
          cnt_d   = 16'd0;
        end
      end
      GAP_B: begin
        if (cnt_q == 16'(CS_GAP - 1)) begin
          state_d  = LATCH;
          cnt_d    = 16'd0;
          latchn_d = 1'b0;
          laser_d  = rgb_q;
        end
      end
      LATCH: begin
        if (cnt_q == 16'(LATCH_CYC - 1)) begin
          latchn_d = 1'b1;
          cnt_d    = dwell_q;
          state_d  = (dwell_q == 16'd0) ? IDLE : DWELL;
        end
      end
      DWELL: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
      dwell_q  <= '0;
      laser_q  <= '0;
      latchn_q <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      laser_q  <= laser_d;
      latchn_q <= latchn_d;
      ready_q  <= (state_d == IDLE);
      if (accept) begin
        y_q     <= pt.pt_y;
        rgb_q   <= pt.pt_rgb;
        dwell_q <= pt.pt_dwell;
      end
    end
  end

  dac_word_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .word_i (word),
    .done_o (done),
    .sclk_o (dac_sclk),
    .mosi_o (dac_mosi),
    .csn_o  (dac_csn)
  );

  assign pt.pt_ready = ready_q;
  assign dac_latchn  = latchn_q;
  assign laser_rgb   = laser_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_galvo_dac_sequencer.sv
// Directed bench: default-parameter sequencer plus a CLK_DIV=1 instance, DAC words decoded from the serial bus.
module tb_galvo_dac_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  galvo_dac_sequencer_if pif();
  galvo_dac_sequencer_if pif1();

  logic       csn0, sclk0, mosi0, latchn0, busy0;
  logic [2:0] laser0;
  logic       csn1, sclk1, mosi1, latchn1, busy1;
  logic [2:0] laser1;

  galvo_dac_sequencer dut (
    .clk(clk), .reset(reset), .pt(pif),
    .dac_csn(csn0), .dac_sclk(sclk0), .dac_mosi(mosi0), .dac_latchn(latchn0),
    .laser_rgb(laser0), .busy(busy0)
  );

  galvo_dac_sequencer #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .pt(pif1),
    .dac_csn(csn1), .dac_sclk(sclk1), .dac_mosi(mosi1), .dac_latchn(latchn1),
    .laser_rgb(laser1), .busy(busy1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Bus monitor: decodes words on sclk rising edges of the selected instance
  logic        sel = 1'b0;
  wire         m_csn  = sel ? csn1  : csn0;
  wire         m_sclk = sel ? sclk1 : sclk0;
  wire         m_mosi = sel ? mosi1 : mosi0;
  logic [15:0] rx = '0;
  int          nb = 0;
  int          lowc = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_csn = 1'b1;
  logic [15:0] words[$];
  int          lens[$];

  always @(negedge clk) begin
    if (m_csn === 1'b0) begin
      lowc <= lowc + 1;
      if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
        rx <= {rx[14:0], m_mosi};
        nb <= nb + 1;
      end
    end else if (m_csn === 1'b1 && prev_csn === 1'b0) begin
      if (nb == 16) words.push_back(rx);
      lens.push_back(lowc);
      nb   <= 0;
      lowc <= 0;
    end
    prev_sclk <= m_sclk;
    prev_csn  <= m_csn;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [11:0] x, input logic [11:0] y, input logic [2:0] rgb,
                       input logic [15:0] d, input bit hold, output int t);
    pif.pt_x = x; pif.pt_y = y; pif.pt_rgb = rgb; pif.pt_dwell = d;
    pif.pt_valid = 1'b1;
    for (int n = 0; n < 1000 && pif.pt_ready !== 1'b1; n++) step();
    check("accept_ready0", {31'd0, pif.pt_ready}, 32'd1);
    step();
    t = cyc;
    if (!hold) pif.pt_valid = 1'b0;
  endtask

  task automatic send1(input logic [11:0] x, input logic [11:0] y, input logic [2:0] rgb,
                       input logic [15:0] d, output int t);
    pif1.pt_x = x; pif1.pt_y = y; pif1.pt_rgb = rgb; pif1.pt_dwell = d;
    pif1.pt_valid = 1'b1;
    for (int n = 0; n < 1000 && pif1.pt_ready !== 1'b1; n++) step();
    check("accept_ready1", {31'd0, pif1.pt_ready}, 32'd1);
    step();
    t = cyc;
    pif1.pt_valid = 1'b0;
  endtask

  initial begin
    int t;
    int t2;
    int cnt;
    pif.pt_valid = 1'b0; pif.pt_x = '0; pif.pt_y = '0; pif.pt_rgb = '0; pif.pt_dwell = '0;
    pif1.pt_valid = 1'b0; pif1.pt_x = '0; pif1.pt_y = '0; pif1.pt_rgb = '0; pif1.pt_dwell = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check("rst_csn", {31'd0, csn0}, 32'd1);
    check("rst_sclk", {31'd0, sclk0}, 32'd0);
    check("rst_mosi", {31'd0, mosi0}, 32'd0);
    check("rst_latchn", {31'd0, latchn0}, 32'd1);
    check("rst_laser", {29'd0, laser0}, 32'd0);
    check("rst_ready", {31'd0, pif.pt_ready}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    reset = 1'b0;
    step();
    check("ready_after_rst", {31'd0, pif.pt_ready}, 32'd1);

    // Basic point, dwell 0; inputs change right after acceptance
    words.delete(); lens.delete();
    send0(12'hABC, 12'h123, 3'b101, 16'd0, 1'b0, t);
    pif.pt_x = 12'h000; pif.pt_y = 12'hFFF; pif.pt_rgb = 3'b010;
    check("t1_ready_drop", {31'd0, pif.pt_ready}, 32'd0);
    check("t1_busy", {31'd0, busy0}, 32'd1);
    check("t1_csn_low", {31'd0, csn0}, 32'd0);
    goto(t + 128); check("t1_gapA_csn", {31'd0, csn0}, 32'd1);
    goto(t + 132); check("t1_shiftB_csn", {31'd0, csn0}, 32'd0);
    goto(t + 263);
    check("t1_pre_latchn", {31'd0, latchn0}, 32'd1);
    check("t1_pre_laser", {29'd0, laser0}, 32'd0);
    goto(t + 264);
    check("t1_latchn_low", {31'd0, latchn0}, 32'd0);
    check("t1_laser", {29'd0, laser0}, 32'h5);
    goto(t + 267); check("t1_latchn_end", {31'd0, latchn0}, 32'd0);
    goto(t + 268);
    check("t1_latchn_high", {31'd0, latchn0}, 32'd1);
    check("t1_ready", {31'd0, pif.pt_ready}, 32'd1);
    check("t1_idle", {31'd0, busy0}, 32'd0);
    check("t1_nwords", words.size(), 32'd2);
    check("t1_wordA", {16'd0, words[0]}, 32'h3ABC);
    check("t1_wordB", {16'd0, words[1]}, 32'hB123);
    check("t1_csn_len", lens[0], 32'd128);

    // Two queued points with valid held, dwell 10
    words.delete(); lens.delete();
    send0(12'h111, 12'h222, 3'b011, 16'd10, 1'b1, t);
    pif.pt_x = 12'h333; pif.pt_y = 12'h444; pif.pt_rgb = 3'b110; pif.pt_dwell = 16'd10;
    goto(t + 264); check("t2_laser1", {29'd0, laser0}, 32'h3);
    goto(t + 277);
    check("t2_dwell_ready", {31'd0, pif.pt_ready}, 32'd0);
    check("t2_dwell_busy", {31'd0, busy0}, 32'd1);
    goto(t + 278); check("t2_ready", {31'd0, pif.pt_ready}, 32'd1);
    step();
    check("t2_accept2_ready", {31'd0, pif.pt_ready}, 32'd0);
    check("t2_accept2_busy", {31'd0, busy0}, 32'd1);
    pif.pt_valid = 1'b0;
    t2 = t + 279;
    goto(t2 + 263); check("t2_laser_hold", {29'd0, laser0}, 32'h3);
    goto(t2 + 264); check("t2_laser2", {29'd0, laser0}, 32'h6);
    goto(t2 + 278); check("t2_ready2", {31'd0, pif.pt_ready}, 32'd1);
    check("t2_nwords", words.size(), 32'd4);
    check("t2_w0", {16'd0, words[0]}, 32'h3111);
    check("t2_w1", {16'd0, words[1]}, 32'hB222);
    check("t2_w2", {16'd0, words[2]}, 32'h3333);
    check("t2_w3", {16'd0, words[3]}, 32'hB444);

    // Reset during SHIFT_B
    words.delete(); lens.delete();
    send0(12'h555, 12'h666, 3'b111, 16'd0, 1'b0, t);
    goto(t + 149);
    reset = 1'b1;
    step();
    check("t3_csn", {31'd0, csn0}, 32'd1);
    check("t3_latchn", {31'd0, latchn0}, 32'd1);
    check("t3_sclk", {31'd0, sclk0}, 32'd0);
    check("t3_laser", {29'd0, laser0}, 32'd0);
    check("t3_busy", {31'd0, busy0}, 32'd0);
    check("t3_ready_rst", {31'd0, pif.pt_ready}, 32'd0);
    reset = 1'b0;
    step();
    check("t3_ready", {31'd0, pif.pt_ready}, 32'd1);
    cnt = 0;
    repeat (300) begin
      if (latchn0 !== 1'b1 || csn0 !== 1'b1) cnt++;
      step();
    end
    check("t3_quiet", cnt, 32'd0);
    check("t3_nwords", words.size(), 32'd1);
    check("t3_wordA", {16'd0, words[0]}, 32'h3555);

    // CLK_DIV=1 instance, full-scale codes
    sel = 1'b1;
    step();
    words.delete(); lens.delete();
    send1(12'hFFF, 12'h000, 3'b010, 16'd0, t);
    goto(t + 71); check("t4_pre_latchn", {31'd0, latchn1}, 32'd1);
    goto(t + 72);
    check("t4_latchn", {31'd0, latchn1}, 32'd0);
    check("t4_laser", {29'd0, laser1}, 32'h2);
    goto(t + 76);
    check("t4_ready", {31'd0, pif1.pt_ready}, 32'd1);
    check("t4_idle", {31'd0, busy1}, 32'd0);
    check("t4_nwords", words.size(), 32'd2);
    check("t4_wordA", {16'd0, words[0]}, 32'h3FFF);
    check("t4_wordB", {16'd0, words[1]}, 32'hB000);
    check("t4_lenA", lens[0], 32'd32);
    check("t4_lenB", lens[1], 32'd32);
    sel = 1'b0;
    step();

    // Maximum dwell
    send0(12'h800, 12'h7FF, 3'b001, 16'hFFFF, 1'b0, t);
    goto(t + 268);
    check("t5_dwell_start", {31'd0, busy0}, 32'd1);
    cnt = 0;
    while (cyc < t + 65802) begin
      if (busy0 !== 1'b1 || pif.pt_ready !== 1'b0) cnt++;
      step();
    end
    check("t5_busy_run", cnt, 32'd0);
    check("t5_last_busy", {31'd0, busy0}, 32'd1);
    check("t5_last_ready", {31'd0, pif.pt_ready}, 32'd0);
    step();
    check("t5_idle", {31'd0, busy0}, 32'd0);
    check("t5_ready", {31'd0, pif.pt_ready}, 32'd1);

    // Random input churn during SHIFT_A
    words.delete(); lens.delete();
    send0(12'h5A5, 12'hA5A, 3'b100, 16'd0, 1'b0, t);
    for (int i = 0; i < 120; i++) begin
      pif.pt_valid = 1'($urandom_range(0, 1));
      pif.pt_x = 12'($urandom);
      pif.pt_y = 12'($urandom);
      step();
    end
    pif.pt_valid = 1'b0;
    goto(t + 264); check("t6_laser", {29'd0, laser0}, 32'h4);
    goto(t + 268); check("t6_ready", {31'd0, pif.pt_ready}, 32'd1);
    check("t6_nwords", words.size(), 32'd2);
    check("t6_wordA", {16'd0, words[0]}, 32'h35A5);
    check("t6_wordB", {16'd0, words[1]}, 32'hBA5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/galvo_dac_sequencer.md
GALVO_DAC_SEQUENCER -- requirements
Module: galvo_dac_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles (min 1).
REQ-002 Parameter CS_GAP, default 4, csn-high cycles between words and before latch.
REQ-003 Parameter LATCH_CYC, default 4, latchn-low pulse length in clk cycles.
REQ-004 clk  in  1  system clock (50 MHz); one clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pt_valid  in  1  point available.
REQ-007 pt_ready  out  1  sequencer can accept a point.
REQ-008 pt_x  in  12  X galvo code (DAC channel A).
REQ-009 pt_y  in  12  Y galvo code (DAC channel B).
REQ-010 pt_rgb  in  3  laser colour for this point.
REQ-011 pt_dwell  in  16  hold cycles after latch.
REQ-012 dac_csn, dac_sclk, dac_mosi, dac_latchn  out  1 each  dual 12-bit DAC serial bus; all registered.
REQ-013 laser_rgb  out  3  active-high laser enables; registered; board inversion is done outside this block.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 A point is accepted on a clk edge where pt_valid and pt_ready are both 1. pt_x, pt_y, pt_rgb and pt_dwell are captured on that edge.
REQ-016 pt_ready is 1 only in IDLE. It drops on the cycle after acceptance.
REQ-017 States are IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B, LATCH and DWELL, visited in that order. DWELL is skipped when the captured dwell is 0.
REQ-018 Word format is {ch, 1'b0 (unbuffered), 1'b1 (1x gain), 1'b1 (active), data[11:0]}. ch=0 for X; ch=1 for Y.
REQ-019 Each word is sent MSB first over 16 bits. For each bit, sclk is low for CLK_DIV cycles and then high for CLK_DIV cycles. mosi changes only while sclk is low. sclk idles low.
REQ-020 csn is low for the whole SHIFT state (16*2*CLK_DIV cycles) and high in every other state.
REQ-021 Cycle timing relative to acceptance edge T, with defaults:
- SHIFT_A: T+1..T+128.
- GAP_A: T+129..T+132.
- SHIFT_B: T+133..T+260.
- GAP_B: T+261..T+264.
- LATCH (latchn=0): T+265..T+268.
- DWELL: T+269..T+268+D.
- pt_ready=1 at T+269+D.
REQ-022 laser_rgb takes the captured pt_rgb on the first LATCH cycle. It holds that value until the next point's LATCH cycle.
REQ-023 The dwell counter is 16-bit and runs down to zero; pt_dwell=16'hFFFF gives 65535 DWELL cycles without wrap.
REQ-024 pt_valid toggling or input changes after acceptance have no effect on the transaction in progress.
REQ-025 Back-to-back points: if pt_valid is held high, the next acceptance occurs on the first IDLE cycle. No idle gap is inserted beyond that one cycle.
REQ-026 pt_x=12'hFFF and 12'h000 are transmitted unmodified; there is no saturation or offset.

Reset
REQ-027 While reset is high, the outputs are forced to: state IDLE, dac_csn=1, dac_sclk=0, dac_mosi=0, dac_latchn=1, laser_rgb=3'b000, pt_ready=0, busy=0.
REQ-028 Reset asserted mid-transaction aborts it on that edge. No partial latch pulse occurs, and csn returns high.
REQ-029 pt_ready rises on the first cycle after reset deasserts.

Structure
REQ-030 Package galvo_pkg holds the state enum, the word config bits (BUF, GA, SHDN), the channel constants, and the CLK_DIV, CS_GAP and LATCH_CYC defaults.
REQ-031 One sub-module, dac_word_shifter, handles the 16-bit word. It takes a load strobe and word, drives sclk, mosi and csn, and returns a done pulse. It is instantiated once and reused for both words.

Verification
REQ-032 Reset, then accept x=12'hABC, y=12'h123, rgb=3'b101, dwell=0. Required response:
- Sampled on sclk rising edges: 16'h3ABC then 16'hB123.
- latchn low at T+265..T+268.
- laser_rgb=3'b101 from T+265.
- pt_ready=1 at T+269.
REQ-033 Send dwell=10 with pt_valid held high and two queued points. Second acceptance occurs at T+279; laser_rgb changes only at the second LATCH.
REQ-034 Assert reset at T+150 (during SHIFT_B). Next cycle shows csn=1, latchn=1, sclk=0, laser_rgb=0. Nothing is latched; pt_ready=1 on the cycle after reset is released.
REQ-035 Send x=12'hFFF, y=12'h000 with CLK_DIV=1. Words 16'h3FFF and 16'hB000 are sent; each csn-low window is exactly 32 cycles.
REQ-036 Send pt_dwell=16'hFFFF. busy stays high for 65535 DWELL cycles; there is no early return to IDLE.
REQ-037 Toggle pt_valid, pt_x and pt_y randomly during SHIFT_A. The transmitted words equal the values captured at acceptance.
